register_file: RTL and testbench
================================

Name: register_file

Overview:
- MIPS-style general-purpose register file for the pipelined datapath (ID-stage reads, WB-stage write).
- 32 registers of 32 bits each.
- Two asynchronous (combinational) read ports and one synchronous write port.
- Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, bit width of each register and of the data ports.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH (32 entries).

Ports:
- Clk  input  1  system clock; all writes occur on the rising edge.
- Reset  input  1  asynchronous, active-high; clears every register to 0.
- ReadRegister1  input  ADDR_WIDTH  index for read port 1.
- ReadRegister2  input  ADDR_WIDTH  index for read port 2.
- WriteRegister  input  ADDR_WIDTH  index for the write port.
- WriteData  input  DATA_WIDTH  value to write.
- RegWrite  input  1  write enable, active-high.
- ReadData1  output  DATA_WIDTH  contents of register ReadRegister1.
- ReadData2  output  DATA_WIDTH  contents of register ReadRegister2.

Behaviour:
- Interface: one clock (Clk); Reset is asynchronous and active-high.
- Reset:
  - On assertion of Reset, all 32 registers clear to 0 immediately, independent of Clk.
  - ReadData1/ReadData2 then reflect 0 combinationally.
  - While Reset is high, writes are ignored.
- Write:
  - On the rising edge of Clk with RegWrite=1 and Reset=0, WriteData is stored into register WriteRegister.
  - Latency: one edge; the new value is visible on the read ports after that edge.
  - RegWrite=0 leaves all registers unchanged.
- Register 0:
  - Writes with WriteRegister=0 are discarded.
  - Reading index 0 always returns 0 on either port.
- Read:
  - Purely combinational. ReadDataN = reg[ReadRegisterN], or 0 for index 0.
  - Outputs update within the same cycle whenever the index or the stored contents change.
  - No clock or enable is involved on the read side.
- Dual read: both ports are independent. The same index on both ports returns the same value.
- Write/read same cycle:
  - No internal bypass. Before the edge, the read port shows the old value; after the edge, the new value.
  - Forwarding is handled outside this block.
- Overwrite: the last write wins. Repeated writes to the same index simply replace the contents.
- Unwritten registers read 0 after reset. Before the first reset, contents are undefined.
- X/unknown inputs: no special handling required.

Test Plan:
1. Reset and unwritten reads: assert Reset, release, read ports 0 and 31 -> ReadData1=0, ReadData2=0.
2. Register-0 protection: RegWrite=1, WriteRegister=0, WriteData=0x1, clock edge; read index 0 -> 0x00000000.
3. Bulk write and paired read-back:
   - Write 8=0x5, 9=0x7, 10=0x9, 15=0xB, 16=0xB, 19=0x6, 20=0xD, 25=0xFFFF on successive edges, then RegWrite=0.
   - Read pairs (9,10) -> 0x7, 0x9.
   - (15,16) -> 0xB, 0xB.
   - (19,20) -> 0x6, 0xD.
   - (25,8) -> 0xFFFF, 0x5.
4. Overwrite: write 21=0x1, then 21=0x14 on the next edge; read (21,31) -> 0x14, 0x0.
5. Write disable and no bypass:
   - With RegWrite=0, drive WriteRegister=8, WriteData=0xDEAD and clock -> reg 8 stays 0x5.
   - With RegWrite=1 and ReadRegister1=8, ReadData1 stays 0x5 until the edge, then shows 0xDEAD.
6. Asynchronous reset mid-operation: after the writes above, pulse Reset between clock edges -> ReadData1/ReadData2 go to 0 immediately; a subsequent read of 25 -> 0.

Source files
------------

// File: rtl/register_file.sv
// ============================================================================
//  Module   : register_file
//  Purpose  : 32 x 32 general-purpose register file, two combinational read
//             ports, one synchronous write port, register 0 reads as zero.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [c_DEPTH];
  logic                  w_writeEn;

  // Index 0 is never stored; the read mux below forces it to zero as well,
  // so the entry stays harmless even before the first reset.
  assign w_writeEn = RegWrite && (WriteRegister != '0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_writeEn) begin
      r_regs[WriteRegister] <= WriteData;
    end
  end

  // No write-to-read bypass: forwarding lives in the pipeline, not here.
  assign ReadData1 = (ReadRegister1 == '0) ? '0 : r_regs[ReadRegister1];
  assign ReadData2 = (ReadRegister2 == '0) ? '0 : r_regs[ReadRegister2];

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
//  Module   : tb_register_file
//  Purpose  : Self-checking bench for register_file: directed scenarios plus
//             randomized traffic compared against an array reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_register_file;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] ReadData1, ReadData2;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  logic [31:0] model [32];

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .RegWrite     (RegWrite),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2)
  );

  always #5 Clk = ~Clk;

  // Reference: reset wipes everything at once, otherwise an enabled edge
  // stores the data unless the target is register 0.
  always @(posedge Reset or posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (RegWrite && WriteRegister != 5'd0) begin
      model[WriteRegister] = WriteData;
    end
  end

  function automatic logic [31:0] expRead(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : model[idx];
  endfunction

  // Continuous comparison midway between active edges.
  always @(negedge Clk) begin
    if (checkEn) begin
      checks++;
      if (ReadData1 !== expRead(ReadRegister1)) begin
        errors++;
        $display("FAIL port1 idx=%0d got=%h exp=%h t=%0t",
                 ReadRegister1, ReadData1, expRead(ReadRegister1), $time);
      end
      checks++;
      if (ReadData2 !== expRead(ReadRegister2)) begin
        errors++;
        $display("FAIL port2 idx=%0d got=%h exp=%h t=%0t",
                 ReadRegister2, ReadData2, expRead(ReadRegister2), $time);
      end
    end
  end

  task automatic checkVal(input string name, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
    RegWrite      = 1'b1;
    WriteRegister = a;
    WriteData     = d;
    tick();
  endtask

  task automatic readPair(input string name, input logic [4:0] a,
                          input logic [4:0] b, input logic [31:0] ea,
                          input logic [31:0] eb);
    ReadRegister1 = a;
    ReadRegister2 = b;
    #1;
    checkVal({name, "_rd1"}, ReadData1, ea);
    checkVal({name, "_rd2"}, ReadData2, eb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    tick(); tick();
    Reset = 1'b0;
    checkEn = 1'b1;

    // 1: reset state and unwritten reads
    readPair("reset", 5'd0, 5'd31, 32'h0, 32'h0);

    // 2: register 0 protection
    writeReg(5'd0, 32'h1);
    RegWrite = 1'b0;
    readPair("reg0", 5'd0, 5'd0, 32'h0, 32'h0);

    // 3: bulk write and paired read-back
    writeReg(5'd8,  32'h5);
    writeReg(5'd9,  32'h7);
    writeReg(5'd10, 32'h9);
    writeReg(5'd15, 32'hB);
    writeReg(5'd16, 32'hB);
    writeReg(5'd19, 32'h6);
    writeReg(5'd20, 32'hD);
    writeReg(5'd25, 32'hFFFF);
    RegWrite = 1'b0;
    readPair("p9_10",  5'd9,  5'd10, 32'h7,    32'h9);
    readPair("p15_16", 5'd15, 5'd16, 32'hB,    32'hB);
    readPair("p19_20", 5'd19, 5'd20, 32'h6,    32'hD);
    readPair("p25_8",  5'd25, 5'd8,  32'hFFFF, 32'h5);

    // 4: overwrite
    writeReg(5'd21, 32'h1);
    writeReg(5'd21, 32'h14);
    RegWrite = 1'b0;
    readPair("ovw", 5'd21, 5'd31, 32'h14, 32'h0);

    // 5: write disable, then no bypass before the edge
    RegWrite = 1'b0; WriteRegister = 5'd8; WriteData = 32'hDEAD;
    tick();
    readPair("wdis", 5'd8, 5'd8, 32'h5, 32'h5);
    RegWrite = 1'b1;
    #1;
    checkVal("nobypass_pre", ReadData1, 32'h5);
    tick();
    RegWrite = 1'b0;
    #1;
    checkVal("nobypass_post", ReadData1, 32'hDEAD);

    // 6: asynchronous reset between edges, then a write held across reset
    ReadRegister1 = 5'd25; ReadRegister2 = 5'd21;
    tick();
    #1;
    Reset = 1'b1;
    #1;
    checkVal("areset_rd1", ReadData1, 32'h0);
    checkVal("areset_rd2", ReadData2, 32'h0);
    RegWrite = 1'b1; WriteRegister = 5'd25; WriteData = 32'h1234;
    tick();
    RegWrite = 1'b0;
    #1;
    Reset = 1'b0;
    readPair("post_reset", 5'd25, 5'd8, 32'h0, 32'h0);

    // Randomized traffic, compared every cycle by the negedge process.
    for (int n = 0; n < 400; n++) begin
      RegWrite      = ($urandom_range(0, 3) != 0);
      WriteRegister = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3))
                                                  : 5'($urandom_range(0, 31));
      WriteData     = $urandom;
      ReadRegister1 = 5'($urandom_range(0, 31));
      ReadRegister2 = ($urandom_range(0, 4) == 0) ? ReadRegister1
                                                  : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 59) == 0) begin
        #1 Reset = 1'b1;
        #1 Reset = 1'b0;
      end
      tick();
    end

    RegWrite = 1'b0;
    tick();
    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
